// File: rtl/regseq_pkg.sv
// regseq_pkg: shared encodings, instruction field positions and FSM states for regfile_seq
package regseq_pkg;
  localparam logic [1:0] CLS_NOP  = 2'b00;
  localparam logic [1:0] CLS_LOAD = 2'b01;
  localparam logic [1:0] CLS_ALU  = 2'b10;
  localparam logic [1:0] CLS_MOV  = 2'b11;
  localparam logic [1:0] EN_IDLE = 2'b00;
  localparam logic [1:0] EN_WR   = 2'b01;
  localparam logic [1:0] EN_RD   = 2'b11;
  localparam logic [1:0] SRC_REG = 2'b00;
  localparam logic [1:0] SRC_OR2 = 2'b10;
  localparam logic [1:0] SRC_ALU = 2'b11;
  localparam int CLS_HI = 7;
  localparam int CLS_LO = 6;
  localparam int RD_HI  = 5;
  localparam int RD_LO  = 3;
  localparam int RS_HI  = 2;
  localparam int RS_LO  = 0;
  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_B, S_EXEC, S_WAIT, S_WB, S_FIN} state_t;
endpackage

// File: rtl/regfile_seq.sv
// regfile_seq: expands 8-bit micro-instructions into register-file read/execute/write-back cycles.
// Optional REGSEQ_R0_PROTECT_EN: suppresses writes to R0 and adds sticky wr_blocked output.
module regfile_seq
  import regseq_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] instr,
  output logic [1:0] enab,
  output logic [1:0] mux_sel,
  output logic [2:0] seg,
  output logic       lat_a,
  output logic       lat_b,
  output logic       alu_go,
  output logic       done,
  output logic       busy
`ifdef REGSEQ_R0_PROTECT_EN
  ,output logic      wr_blocked
`endif
);
  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);
  state_t     r_state, w_nxt;
  logic [1:0] r_cls, w_cls;
  logic [2:0] r_rd, r_rs, w_rd, w_rs;
  logic [3:0] r_cnt;
  logic       w_acc, w_blk;
  logic [1:0] w_enab, w_mux;
  logic [2:0] w_seg;
  assign w_acc = instr_valid && instr_ready;
  assign w_cls = w_acc ? instr[CLS_HI:CLS_LO] : r_cls;
  assign w_rd  = w_acc ? instr[RD_HI:RD_LO] : r_rd;
  assign w_rs  = w_acc ? instr[RS_HI:RS_LO] : r_rs;
`ifdef REGSEQ_R0_PROTECT_EN
  assign w_blk = (w_nxt == S_WB) && (w_rd == 3'd0);
`else
  assign w_blk = 1'b0;
`endif
  always_comb begin
    w_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_nxt = !w_acc ? S_IDLE : w_cls == CLS_NOP ? S_FIN : w_cls == CLS_LOAD ? S_WB : S_RD_A;
      S_RD_A:  w_nxt = w_cls == CLS_ALU ? S_RD_B : S_WB;
      S_RD_B:  w_nxt = S_EXEC;
      S_EXEC:  w_nxt = ALU_LAT == 1 ? S_WB : S_WAIT;
      S_WAIT:  w_nxt = r_cnt == 4'd1 ? S_WB : S_WAIT;
      default: w_nxt = S_IDLE;
    endcase
  end
  // Outputs are decoded from the next state and registered, so every output is a flop.
  always_comb begin
    w_enab = (w_nxt == S_RD_A || w_nxt == S_RD_B) ? EN_RD :
             (w_nxt == S_WB && !w_blk) ? EN_WR : EN_IDLE;
    w_mux  = w_nxt != S_WB ? SRC_REG : w_cls == CLS_LOAD ? SRC_OR2 : w_cls == CLS_ALU ? SRC_ALU : SRC_REG;
    w_seg  = w_nxt == S_RD_A ? (w_cls == CLS_MOV ? w_rs : w_rd) :
             w_nxt == S_RD_B ? w_rs : w_nxt == S_WB ? w_rd : seg;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cls       <= CLS_NOP;
      r_rd        <= '0;
      r_rs        <= '0;
      r_cnt       <= '0;
      enab        <= EN_IDLE;
      mux_sel     <= SRC_REG;
      seg         <= '0;
      lat_a       <= 1'b0;
      lat_b       <= 1'b0;
      alu_go      <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      instr_ready <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_cls       <= w_cls;
      r_rd        <= w_rd;
      r_rs        <= w_rs;
      r_cnt       <= w_nxt == S_EXEC ? LAT_M1 : r_state == S_WAIT ? r_cnt - 4'd1 : r_cnt;
      enab        <= w_enab;
      mux_sel     <= w_mux;
      seg         <= w_seg;
      lat_a       <= w_nxt == S_RD_A;
      lat_b       <= w_nxt == S_RD_B;
      alu_go      <= w_nxt == S_EXEC;
      done        <= w_nxt == S_WB || w_nxt == S_FIN;
      busy        <= w_nxt != S_IDLE;
      instr_ready <= w_nxt == S_IDLE;
    end
  end
`ifdef REGSEQ_R0_PROTECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_blocked <= 1'b0;
    else if (w_blk) wr_blocked <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_regfile_seq.sv
// tb_regfile_seq: timeline model of the sequencer checked every cycle, plus directed literal checks.
module tb_regfile_seq;
  localparam int L = 3;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       instr_ready, lat_a, lat_b, alu_go, done, busy;
  logic [1:0] enab, mux_sel;
  logic [2:0] seg;
`ifdef REGSEQ_R0_PROTECT_EN
  logic       wr_blocked;
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  regfile_seq #(.ALU_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .enab(enab), .mux_sel(mux_sel), .seg(seg), .lat_a(lat_a),
    .lat_b(lat_b), .alu_go(alu_go), .done(done), .busy(busy)
`ifdef REGSEQ_R0_PROTECT_EN
    , .wr_blocked(wr_blocked)
`endif
  );
  typedef struct packed {
    logic [1:0] enab;
    logic [1:0] mux;
    logic [2:0] seg;
    logic la, lb, go, dn, busy, ready, w0;
  } ov_t;
  ov_t cur = '0;
  ov_t q[$];
  bit  m_acc = 1'b0;
  bit  m_blk = 1'b0;
  function automatic ov_t mk(input logic [1:0] e, input logic [1:0] m, input logic [2:0] s,
                             input logic la, input logic lb, input logic go, input logic dn);
    ov_t o = '0;
    o.enab = e; o.mux = m; o.seg = s; o.la = la; o.lb = lb; o.go = go; o.dn = dn; o.busy = 1'b1;
    return o;
  endfunction
  function automatic ov_t wb(input logic [1:0] m, input logic [2:0] rd);
    ov_t o = mk(2'b01, m, rd, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef REGSEQ_R0_PROTECT_EN
    if (rd == 3'd0) begin o.enab = 2'b00; o.w0 = 1'b1; end
`endif
    return o;
  endfunction
  // Expand one accepted instruction into the per-cycle output timeline it must produce.
  function automatic void expand(input logic [7:0] v);
    logic [2:0] rd = v[5:3];
    logic [2:0] rs = v[2:0];
    case (v[7:6])
      2'b00: q.push_back(mk(2'b00, 2'b00, cur.seg, 1'b0, 1'b0, 1'b0, 1'b1));
      2'b01: q.push_back(wb(2'b10, rd));
      2'b10: begin
        q.push_back(mk(2'b11, 2'b00, rd, 1'b1, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(2'b11, 2'b00, rs, 1'b0, 1'b1, 1'b0, 1'b0));
        q.push_back(mk(2'b00, 2'b00, rs, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int i = 1; i < L; i++) q.push_back(mk(2'b00, 2'b00, rs, 1'b0, 1'b0, 1'b0, 1'b0));
        q.push_back(wb(2'b11, rd));
      end
      default: begin
        q.push_back(mk(2'b11, 2'b00, rs, 1'b1, 1'b0, 1'b0, 1'b0));
        q.push_back(wb(2'b00, rd));
      end
    endcase
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cur = '0;
      m_acc = 1'b0;
      m_blk = 1'b0;
    end else begin
      m_acc = instr_valid && cur.ready;
      if (m_acc) expand(instr);
      if (q.size() > 0) cur = q.pop_front();
      else begin
        cur = '{enab: 2'b00, mux: 2'b00, seg: cur.seg, la: 1'b0, lb: 1'b0, go: 1'b0,
                dn: 1'b0, busy: 1'b0, ready: 1'b1, w0: 1'b0};
      end
      if (cur.w0) m_blk = 1'b1;
    end
  end
  function automatic logic [12:0] vis(input ov_t v);
    return {v.enab, v.mux, v.seg, v.la, v.lb, v.go, v.dn, v.busy, v.ready};
  endfunction
  always @(negedge clk) begin
    checks++;
    if ({enab, mux_sel, seg, lat_a, lat_b, alu_go, done, busy, instr_ready} !== vis(cur)) begin
      errors++;
      $display("FAIL cycle t=%0t got=%b want=%b", $time,
               {enab, mux_sel, seg, lat_a, lat_b, alu_go, done, busy, instr_ready}, vis(cur));
    end
`ifdef REGSEQ_R0_PROTECT_EN
    checks++;
    if (wr_blocked !== m_blk) begin
      errors++;
      $display("FAIL wr_blocked_model t=%0t got=%b want=%b", $time, wr_blocked, m_blk);
    end
`endif
  end
  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h want=%0h", n, $time, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] v, input bit hold);
    instr = v;
    instr_valid = 1'b1;
    for (int i = 0; i < 40 && !m_acc; i++) step();
    if (!m_acc) step();
    checks++;
    if (!m_acc) begin
      errors++;
      $display("FAIL accept_timeout instr=%0h got=0 want=1", v);
    end
    if (!hold) instr_valid = 1'b0;
  endtask
  initial begin
    repeat (2) step();
    chk("rst_ready", {7'd0, instr_ready}, 8'd0);
    chk("rst_enab", {6'd0, enab}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", {7'd0, instr_ready}, 8'd0);
    step();
    chk("ready_after_edge", {7'd0, instr_ready}, 8'd1);
    send(8'b01_101_000, 1'b0);
    chk("load_enab", {6'd0, enab}, 8'd1);
    chk("load_mux", {6'd0, mux_sel}, 8'd2);
    chk("load_seg", {5'd0, seg}, 8'd5);
    chk("load_done", {7'd0, done}, 8'd1);
    step();
    chk("load_ready", {7'd0, instr_ready}, 8'd1);
    chk("load_done_off", {7'd0, done}, 8'd0);
    step();
    send(8'b10_010_001, 1'b0);
    chk("alu_rda", {enab, seg, lat_a}, {2'b11, 3'd2, 1'b1});
    step();
    chk("alu_rdb", {enab, seg, lat_b}, {2'b11, 3'd1, 1'b1});
    step();
    chk("alu_go", {enab, alu_go}, {2'b00, 1'b1});
    step();
    chk("alu_wait1", {enab, busy, done}, {2'b00, 1'b1, 1'b0});
    instr = 8'b01_111_111;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("alu_wait2", {enab, instr_ready, done}, {2'b00, 1'b0, 1'b0});
    step();
    chk("alu_wb", {enab, mux_sel, seg, done}, {2'b01, 2'b11, 3'd2, 1'b1});
    step();
    chk("alu_idle", {instr_ready, done, busy}, {1'b1, 1'b0, 1'b0});
    send(8'b11_100_011, 1'b1);
    instr = 8'h00;
    chk("mov_rd", {enab, seg, lat_a}, {2'b11, 3'd3, 1'b1});
    step();
    chk("mov_wb", {enab, mux_sel, seg, done}, {2'b01, 2'b00, 3'd4, 1'b1});
    step();
    chk("mov_idle_gap", {instr_ready, busy}, {1'b1, 1'b0});
    step();
    chk("nop_fin", {enab, seg, done, busy}, {2'b00, 3'd4, 1'b1, 1'b1});
    instr_valid = 1'b0;
    step();
    chk("nop_idle", {enab, done, instr_ready}, {2'b00, 1'b0, 1'b1});
    send(8'b10_010_001, 1'b0);
    step();
    chk("rst_at_rdb", {6'd0, lat_b, enab == 2'b11}, 8'd3);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {enab, lat_a, lat_b, alu_go, done, busy, instr_ready}, 8'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rel_ready0", {7'd0, instr_ready}, 8'd0);
    step();
    chk("rel_ready1", {instr_ready, done}, {1'b1, 1'b0});
    send(8'b01_000_000, 1'b0);
`ifdef REGSEQ_R0_PROTECT_EN
    chk("r0_blocked", {enab, done, wr_blocked}, {2'b00, 1'b1, 1'b1});
    step();
    step();
    chk("r0_sticky", {7'd0, wr_blocked}, 8'd1);
`else
    chk("r0_write", {enab, mux_sel, seg, done}, {2'b01, 2'b10, 3'd0, 1'b1});
    step();
    step();
`endif
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_seq.md
Name: regfile_seq

Overview:
Instruction-level control sequencer that drives the register file's control interface (enab, mux_sel, seg) and the ALU operand/start strobes.
- Accepts one 8-bit micro-instruction per valid/ready handshake.
- Expands it into the multi-cycle read / execute / write-back pattern the register file expects.
- Sits between the decode stage and the register file in the RNBIP-2 datapath.

Parameters:
ALU_LAT, 1, cycles from alu_go to the write-back cycle; legal 1..15.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
instr_valid  input  1  instruction present on instr.
instr_ready  output  1  sequencer can accept an instruction.
instr  input  8  [7:6] class, [5:3] rd, [2:0] rs.
enab  output  2  register-file op: 00 idle, 01 write, 11 read; 10 never driven.
mux_sel  output  2  write source: 00 register feedback, 10 OR2, 11 ALU_IN; 01 never driven.
seg  output  3  register address.
lat_a  output  1  ALU operand-A capture strobe.
lat_b  output  1  ALU operand-B capture strobe.
alu_go  output  1  one-cycle ALU start pulse.
done  output  1  one-cycle completion pulse.
busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock is clk. Reset rst_n is asynchronous, active-low.
- All outputs are registered (Moore); no combinational input-to-output paths.
- Reset values:
  - enab=00, mux_sel=00, seg=000.
  - lat_a=lat_b=alu_go=done=busy=0.
  - instr_ready=0; it rises on the first clk edge after rst_n deasserts.
- Accept: on the edge where instr_valid && instr_ready. Call that edge T. rd, rs and class are latched at T.
- instr_ready is high only in IDLE; minimum one IDLE cycle between instructions.
- Classes and cycle patterns (cycle n = the cycle following edge T+n-1):
  - 00 NOP: T+1 FIN (enab=00, done=1); T+2 IDLE.
  - 01 LOAD: T+1 WB (enab=01, mux_sel=10, seg=rd, done=1); T+2 IDLE.
  - 10 ALU:
    - T+1 RD_A (enab=11, seg=rd, lat_a=1).
    - T+2 RD_B (enab=11, seg=rs, lat_b=1).
    - T+3 EXEC (enab=00, alu_go=1).
    - WAIT for ALU_LAT-1 cycles (enab=00); WAIT is skipped when ALU_LAT=1.
    - T+3+ALU_LAT WB (enab=01, mux_sel=11, seg=rd, done=1).
    - Then IDLE.
  - 11 MOV: T+1 RD_A (enab=11, seg=rs, lat_a=1); T+2 WB (enab=01, mux_sel=00, seg=rd, done=1); then IDLE.
- State list: IDLE, RD_A, RD_B, EXEC, WAIT, WB, FIN. WAIT uses a 4-bit down-counter loaded with ALU_LAT-1 in EXEC.
- Outside WB, mux_sel holds 00.
- Outside read/write cycles, seg holds its last value.
- Strobes (lat_a, lat_b, alu_go, done) are exactly one cycle wide.
- instr_valid while busy is ignored; it is not queued.
- instr is sampled only at accept; changes after accept have no effect.
- Reset mid-operation: FSM returns to IDLE immediately (async). enab is forced to 00 at once, so no partial write completes. done is not asserted.
- rd == rs is legal: both reads address the same register.

Optional Feature:
REGSEQ_R0_PROTECT_EN.
- Defined: any WB with rd==000 drives enab=00 instead of 01. done still pulses, and a sticky output wr_blocked (1 bit, reset 0) is set; it clears on reset only.
- Undefined: R0 is writable like any register, and the wr_blocked port does not exist.

Decomposition:
- Shared package regseq_pkg:
  - class codes CLS_NOP/LOAD/ALU/MOV.
  - enab encodings EN_IDLE/EN_WR/EN_RD.
  - mux_sel encodings SRC_REG/SRC_OR2/SRC_ALU.
  - FSM state enum.
  - instruction field bit positions.
- No sub-module; the latency counter stays inline.

Test Plan:
- Reset: assert rst_n=0 mid-ALU-op at RD_B -> enab=00 and all strobes 0 immediately; instr_ready=1 one edge after release.
- LOAD: instr=8'b01_101_000 accepted at T -> at T+1 enab=01, mux_sel=10, seg=5, done=1; instr_ready=1 at T+2.
- ALU, ALU_LAT=3: instr=8'b10_010_001 -> T+1 seg=2 lat_a; T+2 seg=1 lat_b; T+3 alu_go; T+4..T+5 enab=00; T+6 enab=01, mux_sel=11, seg=2, done.
- MOV then NOP, valid held high continuously: instr=8'b11_100_011 -> read seg=3, then write seg=4 with mux_sel=00; the second instruction is accepted only after one IDLE cycle; NOP gives done with enab=00 throughout.
- Busy rejection: pulse instr_valid during WAIT with a different instr -> ignored; no extra done pulse; instr_ready stays 0 until IDLE.
- REGSEQ_R0_PROTECT_EN defined: LOAD to rd=0 -> enab stays 00, done=1, wr_blocked=1 and stays set.
